// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
//==============================================================================
// Module  : fifo_uart_tx_pkg
// Brief   : Shared states, serial line levels and sizing helper for fifo_uart_tx
// Revision: 1.0 - initial release
//==============================================================================
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width of a counter spanning 0..clks_per_bit-1 (never below one bit).
    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_bit_timer.sv
`default_nettype none
//==============================================================================
// Module  : bit_timer
// Brief   : Free-running 0..CLKS_PER_BIT-1 counter flagging the last cycle of a bit
// Revision: 1.0 - initial release
//==============================================================================
module bit_timer
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                 c_CNT_W = timer_width(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || (r_count == c_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_end = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
//==============================================================================
// Module  : fifo_uart_tx
// Brief   : Pops words from a FIFO read port and sends each as a start/data/stop frame
// Revision: 1.0 - initial release
//==============================================================================
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int RD_LATENCY   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frames_sent
);

    localparam int                  c_IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int                  c_WAIT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(WIDTH - 1);
    localparam logic [c_WAIT_W-1:0] c_LAST_WAIT = c_WAIT_W'(RD_LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_shift;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [7:0]          r_frames_sent;
    logic                w_bit_end;
    logic                w_timer_clear;
    logic                w_start_ok;
    logic                w_wait_done;

    assign w_start_ok    = enable && !fifo_empty;
    assign w_wait_done   = (r_wait_cnt == c_LAST_WAIT);
    // Holding the timer clear outside the frame makes it restart at 0 on entry to START.
    assign w_timer_clear = (r_state == IDLE) || (r_state == POP) || (r_state == WAIT);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_next = POP;
            POP:     w_state_next = WAIT;
            WAIT:    if (w_wait_done) w_state_next = START;
            START:   if (w_bit_end) w_state_next = DATA;
            DATA:    if (w_bit_end && (r_bit_idx == c_LAST_IDX)) w_state_next = STOP;
            STOP:    if (w_bit_end) w_state_next = w_start_ok ? POP : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_wait_cnt    <= '0;
            r_frames_sent <= '0;
        end else begin
            if ((r_state == WAIT) && !w_wait_done) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            // The word is captured once; later fifo_data activity cannot disturb the frame.
            if ((r_state == WAIT) && w_wait_done) begin
                r_shift <= fifo_data;
            end

            if (w_bit_end) begin
                if ((r_state == START) || ((r_state == DATA) && (r_bit_idx == c_LAST_IDX))) begin
                    r_bit_idx <= '0;
                end else if (r_state == DATA) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end

            if ((r_state == STOP) && w_bit_end) begin
                r_frames_sent <= r_frames_sent + 8'd1;
            end
        end
    end

    always_comb begin
        tx         = STOP_BIT;
        fifo_read  = 1'b0;
        frame_done = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            POP:     fifo_read  = 1'b1;
            START:   tx         = START_BIT;
            DATA:    tx         = r_shift[r_bit_idx];
            STOP:    frame_done = w_bit_end;
            default: tx         = STOP_BIT;
        endcase
    end

    assign frames_sent = r_frames_sent;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
//==============================================================================
// Module  : tb_fifo_uart_tx
// Brief   : Self-checking bench for fifo_uart_tx with a 1-cycle-latency FIFO model
// Revision: 1.0 - initial release
//==============================================================================
module tb_fifo_uart_tx;

    localparam int c_W   = 8;
    localparam int c_CPB = 4;
    localparam int c_FRM = (c_W + 2) * c_CPB;

    typedef struct packed {
        logic [7:0] word;
        logic [9:0] frame;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic           fifo_empty;
    logic [c_W-1:0] fifo_data = '0;
    logic           fifo_read;
    logic           tx;
    logic           busy;
    logic           frame_done;
    logic [7:0]     frames_sent;

    fifo_uart_tx #(
        .WIDTH        (c_W),
        .CLKS_PER_BIT (c_CPB),
        .RD_LATENCY   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read   (fifo_read),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // FIFO model: data valid one cycle after the pop edge, otherwise optionally noise.
    logic [7:0] fifo_mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       scramble = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= fifo_mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end else if (scramble) begin
            fifo_data <= 8'($urandom);
        end
    end

    // Line monitor: records each complete frame as seen on tx.
    logic       in_frame = 1'b0;
    int         cyc = 0;
    logic [9:0] cur_bits = '0;
    logic       stable = 1'b0;
    logic       fd_ok = 1'b0;
    int         gap = 0;
    int         cap_cnt = 0;
    int         rd_cnt = 0;
    int         fd_cnt = 0;
    logic [9:0] cap_frame  [512];
    logic       cap_stable [512];
    logic       cap_fd     [512];
    int         cap_gap    [512];

    always @(negedge clk) begin
        if (fifo_read)  rd_cnt <= rd_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (!reset) begin
            in_frame <= 1'b0;
        end else if (!in_frame) begin
            if (tx == 1'b0) begin
                in_frame         <= 1'b1;
                cyc              <= 1;
                cur_bits         <= '0;
                stable           <= 1'b1;
                fd_ok            <= !frame_done;
                cap_gap[cap_cnt] <= gap;
            end else begin
                gap <= gap + 1;
            end
        end else begin
            if (cyc % c_CPB == 0) cur_bits[cyc / c_CPB] <= tx;
            else if (tx != cur_bits[cyc / c_CPB]) stable <= 1'b0;
            if (cyc == c_FRM - 1) begin
                cap_frame[cap_cnt]  <= cur_bits;
                cap_stable[cap_cnt] <= stable && (tx == cur_bits[9]);
                cap_fd[cap_cnt]     <= fd_ok && frame_done;
                cap_cnt             <= cap_cnt + 1;
                in_frame            <= 1'b0;
                gap                 <= 0;
            end else begin
                fd_ok <= fd_ok && !frame_done;
                cyc   <= cyc + 1;
            end
        end
    end

    int         tests = 0;
    int         fails = 0;
    int         chk_idx = 0;
    logic [7:0] exp_sent = '0;
    logic [9:0] exp_q [$];
    vec_t       vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w, input logic [9:0] f);
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(f);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while ((cap_cnt < target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait_timeout", 32'(cap_cnt >= target), 32'd1);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!in_frame && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("start_wait_timeout", 32'(in_frame), 32'd1);
    endtask

    task automatic check_frames();
        logic [9:0] f;
        while (chk_idx < cap_cnt) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got 0x%0h, expected no frame", cap_frame[chk_idx]);
            end else begin
                f = exp_q.pop_front();
                check("frame_bits", 32'(cap_frame[chk_idx]), 32'(f));
                check("bit_timing", 32'(cap_stable[chk_idx]), 32'd1);
                check("frame_done_pulse", 32'(cap_fd[chk_idx]), 32'd1);
                exp_sent = exp_sent + 8'd1;
            end
            chk_idx++;
        end
    endtask

    initial begin
        int base;
        int rd0;
        int fd0;
        int n;
        logic [7:0] w;

        vecs[0] = '{word: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{word: 8'h01, frame: 10'b1000000010};
        vecs[2] = '{word: 8'h02, frame: 10'b1000000100};
        vecs[3] = '{word: 8'h03, frame: 10'b1000000110};
        vecs[4] = '{word: 8'h3C, frame: 10'b1001111000};
        vecs[5] = '{word: 8'hFF, frame: 10'b1111111110};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_empty_busy", 32'(busy), 32'd0);

        // Single 0xA5 frame: pop handshake and start latency
        @(posedge clk); #1;
        push_word(vecs[0].word, vecs[0].frame);
        @(negedge clk);
        check("pop_not_yet", 32'(fifo_read), 32'd0);
        @(negedge clk);
        check("pop_pulse", 32'(fifo_read), 32'd1);
        check("pop_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wait_read_low", 32'(fifo_read), 32'd0);
        check("wait_tx_high", 32'(tx), 32'd1);
        @(negedge clk);
        check("start_tx_low", 32'(tx), 32'd0);
        wait_frames(1, 100);
        repeat (3) @(negedge clk);
        check_frames();
        check("t1_frames_sent", 32'(frames_sent), 32'(exp_sent));
        check("t1_rd_cnt", 32'(rd_cnt), 32'd1);
        check("t1_fd_cnt", 32'(fd_cnt), 32'd1);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Table: one isolated frame per vector
        for (int i = 0; i < 6; i++) begin
            base = cap_cnt;
            @(posedge clk); #1;
            push_word(vecs[i].word, vecs[i].frame);
            wait_frames(base + 1, 100);
            repeat (3) @(negedge clk);
            check_frames();
            check("tbl_frames_sent", 32'(frames_sent), 32'(exp_sent));
            check("tbl_busy_idle", 32'(busy), 32'd0);
        end

        // Back-to-back 0x01, 0x02, 0x03
        base = cap_cnt;
        rd0  = rd_cnt;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) push_word(vecs[i].word, vecs[i].frame);
        wait_frames(base + 3, 250);
        repeat (3) @(negedge clk);
        check_frames();
        check("b2b_gap1", 32'(cap_gap[base + 1]), 32'd2);
        check("b2b_gap2", 32'(cap_gap[base + 2]), 32'd2);
        check("b2b_reads", 32'(rd_cnt - rd0), 32'd3);
        check("b2b_frames_sent", 32'(frames_sent), 32'(exp_sent));
        check("b2b_busy_idle", 32'(busy), 32'd0);

        // enable dropped mid-frame
        base = cap_cnt;
        rd0  = rd_cnt;
        @(posedge clk); #1;
        push_word(vecs[4].word, vecs[4].frame);
        push_word(vecs[2].word, vecs[2].frame);
        wait_start(20);
        repeat (12) @(posedge clk);
        #1 enable = 1'b0;
        wait_frames(base + 1, 100);
        repeat (30) @(negedge clk);
        check_frames();
        check("en_off_reads", 32'(rd_cnt - rd0), 32'd1);
        check("en_off_frames", 32'(cap_cnt - base), 32'd1);
        check("en_off_tx", 32'(tx), 32'd1);
        check("en_off_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_frames(base + 2, 100);
        repeat (3) @(negedge clk);
        check_frames();
        check("en_on_reads", 32'(rd_cnt - rd0), 32'd2);
        check("en_on_frames_sent", 32'(frames_sent), 32'(exp_sent));

        // Reset during bit 3 of a 0xFF frame
        base = cap_cnt;
        @(posedge clk); #1;
        push_word(vecs[5].word, vecs[5].frame);
        push_word(vecs[4].word, vecs[4].frame);
        wait_start(20);
        repeat (16) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fifo_read", 32'(fifo_read), 32'd0);
        check("midrst_frames_sent", 32'(frames_sent), 32'd0);
        void'(exp_q.pop_front());
        exp_sent = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_frames(base + 1, 100);
        repeat (3) @(negedge clk);
        check("midrst_aborted", 32'(cap_cnt - base), 32'd1);
        check_frames();
        check("midrst_after_sent", 32'(frames_sent), 32'(exp_sent));

        // fifo_data noise after the capture edge
        base = cap_cnt;
        scramble = 1'b1;
        @(posedge clk); #1;
        push_word(vecs[0].word, vecs[0].frame);
        push_word(vecs[5].word, vecs[5].frame);
        wait_frames(base + 2, 150);
        repeat (3) @(negedge clk);
        check_frames();
        check("noise_frames_sent", 32'(frames_sent), 32'(exp_sent));

        // Drive frames_sent to 255, then one more to wrap
        base = cap_cnt;
        n    = 255 - int'(exp_sent);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            w = 8'($urandom);
            push_word(w, {1'b1, w, 1'b0});
        end
        wait_frames(base + n, n * (c_FRM + 4) + 100);
        repeat (3) @(negedge clk);
        check_frames();
        check("pre_wrap_sent", 32'(frames_sent), 32'd255);
        base = cap_cnt;
        fd0  = fd_cnt;
        @(posedge clk); #1;
        push_word(vecs[4].word, vecs[4].frame);
        wait_frames(base + 1, 100);
        repeat (3) @(negedge clk);
        check_frames();
        check("wrap_sent", 32'(frames_sent), 32'd0);
        check("wrap_frame_done", 32'(fd_cnt - fd0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
